// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use/branch-operand bubbles, memory freeze,
// and squash on taken branches and traps, with a stall-cycle counter.
package hazard_pkg;
    typedef enum logic [1:0] {
        NoType  = 2'd0,
        Type1   = 2'd1,
        Type2   = 2'd2,
        Type1_3 = 2'd3
    } forwarding_type_t;
endpackage

module hazard_unit
    import hazard_pkg::*;
#(
    parameter int CntWidth = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  forwarding_type_t    forwarding_type_id,
    input  logic [4:0]          rs1_id,
    input  logic [4:0]          rs2_id,
    input  logic [4:0]          rd_ex,
    input  logic                reg_we_ex,
    input  logic                zicsr_ex,
    input  logic                mem_rd_en_ex,
    input  logic [4:0]          rd_mem,
    input  logic                mem_rd_en_mem,
    input  logic                take_branch_id,
    input  logic                trap,
    input  logic                mem_busy,
    output logic                stall_if,
    output logic                stall_id,
    output logic                stall_ex,
    output logic                stall_mem,
    output logic                flush_id,
    output logic                flush_ex,
    output logic                flush_mem,
    output logic [CntWidth-1:0] stall_cycles
);

    typedef enum logic {Run, Bubble} state_t;

    state_t                state_q, state_d;
    logic [1:0]            bubble_cnt_q, bubble_cnt_d;
    logic [CntWidth-1:0]   stall_cycles_q;

    logic ex_hit1, ex_hit2, mem_hit;
    logic is_t1, is_t2;
    logic need2, need1;

    assign ex_hit1 = (rd_ex != 5'd0) && (rd_ex == rs1_id);
    assign ex_hit2 = (rd_ex != 5'd0) && (rd_ex == rs2_id);
    assign mem_hit = (rd_mem != 5'd0)
                   && ((rd_mem == rs1_id) || (rd_mem == rs2_id));

    assign is_t2 = (forwarding_type_id == Type2);
    assign is_t1 = (forwarding_type_id == Type1)
                || (forwarding_type_id == Type1_3);

    assign need2 = is_t2 && mem_rd_en_ex && (ex_hit1 || ex_hit2);

    // CSR results reach ID through the rs1 path only
    assign need1 = (is_t1 && mem_rd_en_ex && (ex_hit1 || ex_hit2))
                || (is_t2 && reg_we_ex && !zicsr_ex && ex_hit1)
                || (is_t2 && reg_we_ex && ex_hit2)
                || (is_t2 && mem_rd_en_mem && mem_hit);

    always_comb begin
        state_d      = state_q;
        bubble_cnt_d = bubble_cnt_q;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        stall_mem    = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        flush_mem    = 1'b0;
        if (!reset) begin
            state_d      = Run;
            bubble_cnt_d = 2'd0;
        end else if (trap) begin
            flush_id     = 1'b1;
            flush_ex     = 1'b1;
            flush_mem    = 1'b1;
            state_d      = Run;
            bubble_cnt_d = 2'd0;
        end else if (mem_busy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (state_q == Bubble) begin
            stall_if     = 1'b1;
            stall_id     = 1'b1;
            flush_ex     = 1'b1;
            bubble_cnt_d = bubble_cnt_q - 2'd1;
            if (bubble_cnt_d == 2'd0) begin
                state_d = Run;
            end
        end else if (need2 || need1) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
            if (need2) begin
                state_d      = Bubble;
                bubble_cnt_d = 2'd1;
            end
        end else if (take_branch_id) begin
            flush_id = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= Run;
            bubble_cnt_q   <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            bubble_cnt_q <= bubble_cnt_d;
            if (stall_if && !(&stall_cycles_q)) begin
                stall_cycles_q <= stall_cycles_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: single-cycle vector table in Run state
// plus hand-written multi-cycle sequences.
module tb_hazard_unit;
    import hazard_pkg::*;

    logic             clock;
    logic             reset;
    forwarding_type_t forwarding_type_id;
    logic [4:0]       rs1_id, rs2_id, rd_ex, rd_mem;
    logic             reg_we_ex, zicsr_ex, mem_rd_en_ex, mem_rd_en_mem;
    logic             take_branch_id, trap, mem_busy;
    logic             stall_if, stall_id, stall_ex, stall_mem;
    logic             flush_id, flush_ex, flush_mem;
    logic [31:0]      stall_cycles;
    logic             s_if, s_id, s_ex, s_mem, f_id, f_ex, f_mem;
    logic [1:0]       sat_cycles;

    int checks = 0;
    int errors = 0;

    hazard_unit #(.CntWidth(32)) dut (
        .clock(clock), .reset(reset),
        .forwarding_type_id(forwarding_type_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_ex(rd_ex), .reg_we_ex(reg_we_ex), .zicsr_ex(zicsr_ex),
        .mem_rd_en_ex(mem_rd_en_ex),
        .rd_mem(rd_mem), .mem_rd_en_mem(mem_rd_en_mem),
        .take_branch_id(take_branch_id), .trap(trap), .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id),
        .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .stall_cycles(stall_cycles)
    );

    hazard_unit #(.CntWidth(2)) u_sat (
        .clock(clock), .reset(reset),
        .forwarding_type_id(forwarding_type_id),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rd_ex(rd_ex), .reg_we_ex(reg_we_ex), .zicsr_ex(zicsr_ex),
        .mem_rd_en_ex(mem_rd_en_ex),
        .rd_mem(rd_mem), .mem_rd_en_mem(mem_rd_en_mem),
        .take_branch_id(take_branch_id), .trap(trap), .mem_busy(mem_busy),
        .stall_if(s_if), .stall_id(s_id),
        .stall_ex(s_ex), .stall_mem(s_mem),
        .flush_id(f_id), .flush_ex(f_ex), .flush_mem(f_mem),
        .stall_cycles(sat_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [1:0] ft;
        logic [4:0] rs1, rs2, rdx, rdm;
        logic       we, csr, ldx, ldm, br, tr, busy;
        logic [6:0] exp;
    } vec_t;

    // exp = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem}
    localparam logic [6:0] NONE  = 7'b0000000;
    localparam logic [6:0] BUBL  = 7'b1100010;
    localparam logic [6:0] FRZ   = 7'b1111000;
    localparam logic [6:0] BRNCH = 7'b0000100;
    localparam logic [6:0] SQSH  = 7'b0000111;

    function automatic logic [6:0] outs();
        return {stall_if, stall_id, stall_ex, stall_mem,
                flush_id, flush_ex, flush_mem};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ft, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rdx,
                         input logic we, input logic csr, input logic ldx,
                         input logic [4:0] rdm, input logic ldm,
                         input logic br, input logic tr, input logic busy);
        forwarding_type_id = forwarding_type_t'(ft);
        rs1_id = rs1; rs2_id = rs2; rd_ex = rdx;
        reg_we_ex = we; zicsr_ex = csr; mem_rd_en_ex = ldx;
        rd_mem = rdm; mem_rd_en_mem = ldm;
        take_branch_id = br; trap = tr; mem_busy = busy;
    endtask

    task automatic idle();
        drive(2'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
    endtask

    task automatic step(input string name, input logic [6:0] exp);
        #1;
        chk(name, {25'd0, outs()}, {25'd0, exp});
    endtask

    task automatic do_reset(input string name);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk({name, "_rst_outs"}, {25'd0, outs()}, 32'd0);
        chk({name, "_rst_cnt"}, stall_cycles, 32'd0);
        idle();
        @(negedge clock);
        reset = 1'b1;
    endtask

    vec_t vt[$];
    int   exp_stalls;

    initial begin
        reset = 1'b0;
        idle();
        #12;
        chk("reset_outs", {25'd0, outs()}, 32'd0);
        chk("reset_cnt", stall_cycles, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        //        name         ft rs1 rs2 rdx rdm we csr ldx ldm br tr busy exp
        vt.push_back('{"idle",     2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0,0,0,0,0,0,0, NONE});
        vt.push_back('{"ld_use_t1",2'd1, 5'd5, 5'd1, 5'd5, 5'd0, 1,0,1,0,0,0,0, BUBL});
        vt.push_back('{"ld_use_t13",2'd3,5'd2, 5'd9, 5'd9, 5'd0, 1,0,1,0,0,0,0, BUBL});
        vt.push_back('{"x0_load",  2'd1, 5'd0, 5'd0, 5'd0, 5'd0, 1,0,1,0,0,0,0, NONE});
        vt.push_back('{"csr_rs1",  2'd2, 5'd3, 5'd8, 5'd3, 5'd0, 1,1,0,0,0,0,0, NONE});
        vt.push_back('{"csr_rs2",  2'd2, 5'd8, 5'd3, 5'd3, 5'd0, 1,1,0,0,0,0,0, BUBL});
        vt.push_back('{"alu_t2",   2'd2, 5'd4, 5'd8, 5'd4, 5'd0, 1,0,0,0,0,0,0, BUBL});
        vt.push_back('{"memld_t2", 2'd2, 5'd6, 5'd8, 5'd1, 5'd6, 0,0,0,1,0,0,0, BUBL});
        vt.push_back('{"memld_t1", 2'd1, 5'd6, 5'd8, 5'd1, 5'd6, 0,0,0,1,0,0,0, NONE});
        vt.push_back('{"alu_t1",   2'd1, 5'd5, 5'd8, 5'd5, 5'd0, 1,0,0,0,0,0,0, NONE});
        vt.push_back('{"x0_memld", 2'd2, 5'd0, 5'd0, 5'd1, 5'd0, 0,0,0,1,0,0,0, NONE});
        vt.push_back('{"branch",   2'd2, 5'd1, 5'd2, 5'd3, 5'd4, 0,0,0,0,1,0,0, BRNCH});
        vt.push_back('{"br_ignored",2'd1,5'd5, 5'd1, 5'd5, 5'd0, 1,0,1,0,1,0,0, BUBL});
        vt.push_back('{"busy",     2'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0,0,0,0,1,0,1, FRZ});
        vt.push_back('{"busy_need",2'd2, 5'd7, 5'd0, 5'd7, 5'd0, 1,0,1,0,0,0,1, FRZ});
        vt.push_back('{"trap_all", 2'd2, 5'd7, 5'd0, 5'd7, 5'd0, 1,0,1,0,1,1,1, SQSH});
        vt.push_back('{"notype_ld",2'd0, 5'd5, 5'd5, 5'd5, 5'd5, 1,0,1,1,0,0,0, NONE});

        exp_stalls = 0;
        foreach (vt[i]) begin
            @(negedge clock);
            drive(vt[i].ft, vt[i].rs1, vt[i].rs2, vt[i].rdx, vt[i].we,
                  vt[i].csr, vt[i].ldx, vt[i].rdm, vt[i].ldm, vt[i].br,
                  vt[i].tr, vt[i].busy);
            step(vt[i].name, vt[i].exp);
            if (vt[i].exp[6]) exp_stalls++;
        end
        @(negedge clock);
        idle();
        step("tbl_tail", NONE);
        chk("tbl_cnt", stall_cycles, 32'(exp_stalls));

        // load-use: one bubble
        do_reset("lu");
        @(negedge clock);
        drive(2'd1, 5'd5, 5'd0, 5'd5, 1, 0, 1, 5'd0, 0, 0, 0, 0);
        step("lu_c0", BUBL);
        @(negedge clock); idle();
        step("lu_c1", NONE);
        chk("lu_cnt", stall_cycles, 32'd1);

        // branch after load: Run -> Bubble -> Run, branch ignored in Bubble
        do_reset("bl");
        @(negedge clock);
        drive(2'd2, 5'd1, 5'd7, 5'd7, 1, 0, 1, 5'd0, 0, 1, 0, 0);
        step("bl_c0", BUBL);
        @(negedge clock);
        drive(2'd2, 5'd1, 5'd7, 5'd0, 0, 0, 0, 5'd7, 1, 1, 0, 0);
        step("bl_c1", BUBL);
        @(negedge clock);
        drive(2'd2, 5'd1, 5'd7, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0);
        step("bl_c2", BRNCH);
        chk("bl_cnt", stall_cycles, 32'd2);

        // memory freeze in the middle of a bubble
        do_reset("mf");
        @(negedge clock);
        drive(2'd2, 5'd7, 5'd0, 5'd7, 1, 0, 1, 5'd0, 0, 0, 0, 0);
        step("mf_c0", BUBL);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            idle();
            mem_busy = 1'b1;
            step("mf_busy", FRZ);
        end
        @(negedge clock); idle();
        step("mf_resume", BUBL);
        @(negedge clock);
        step("mf_run", NONE);
        chk("mf_cnt", stall_cycles, 32'd5);
        chk("mf_sat", {30'd0, sat_cycles}, 32'd3);

        // trap cancels a pending bubble
        do_reset("tp");
        @(negedge clock);
        drive(2'd2, 5'd7, 5'd0, 5'd7, 1, 0, 1, 5'd0, 0, 0, 0, 0);
        step("tp_c0", BUBL);
        @(negedge clock); idle();
        trap = 1'b1;
        step("tp_trap", SQSH);
        @(negedge clock); idle();
        step("tp_after", NONE);
        chk("tp_cnt", stall_cycles, 32'd1);

        // reset asserted while in Bubble
        do_reset("rb0");
        @(negedge clock);
        drive(2'd2, 5'd7, 5'd0, 5'd7, 1, 0, 1, 5'd0, 0, 0, 0, 0);
        step("rb_c0", BUBL);
        do_reset("rb");
        @(negedge clock); idle();
        step("rb_after", NONE);
        chk("rb_cnt", stall_cycles, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
